cpu_request_arbiter: RTL

Parametrised next-generation CPU-to-memory request unit. It alternates instruction fetch and data load/store over a single shared memory port. Fetched instructions and loaded data are held in output registers. The data phase is skipped when the instruction needs no memory access, and a busy watchdog flags a hung memory. It sits between the single-cycle CPU core and the memory/wishbone-side controller, and gates CPU advance through a one-cycle enable pulse.

---
 rtl/cpu_request_arbiter_if.sv | 36 +++
 rtl/cpu_request_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_request_arbiter_if
// Shared memory-port bundle between the CPU request arbiter and the
// memory/wishbone-side controller.
//   mem_busy       : memory still working on the presented request
//   data_from_mem  : read data, valid in the completion cycle
//   write_to_mem   : write strobe
//   read_to_mem    : read strobe
//   sel_to_mem     : byte selects
//   adr_to_mem     : request address
//   data_to_mem    : write data
// master modport = arbiter side, slave modport = memory side.
// -----------------------------------------------------------------------------
interface cpu_request_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = DATA_W / 8
);
   logic              mem_busy;
   logic [DATA_W-1:0] data_from_mem;
   logic              write_to_mem;
   logic              read_to_mem;
   logic [SEL_W-1:0]  sel_to_mem;
   logic [ADDR_W-1:0] adr_to_mem;
   logic [DATA_W-1:0] data_to_mem;

   modport master (
      input  mem_busy, data_from_mem,
      output write_to_mem, read_to_mem, sel_to_mem, adr_to_mem, data_to_mem
   );

   modport slave (
      output mem_busy, data_from_mem,
      input  write_to_mem, read_to_mem, sel_to_mem, adr_to_mem, data_to_mem
   );
endinterface

// File: rtl/cpu_request_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_request_arbiter
// Alternates instruction fetch and data load/store over one shared memory
// port for a single-cycle CPU core. The fetched instruction and loaded data
// are registered; a one-cycle enable pulse lets the CPU commit and advance.
// A busy watchdog moves to a sticky ERROR state when memory hangs.
// Ports:
//   clk, nRst                : clock, asynchronous active-low reset
//   read_from_CPU/write_from_CPU/sel_from_CPU : load/store request
//   instruction_adr_from_CPU : PC for the next fetch
//   data_adr_from_CPU, data_from_CPU : load/store address and store data
//   enable                   : one-cycle commit pulse to the CPU
//   instruction, data        : registered instruction and load result
//   bus_error                : sticky watchdog flag
//   mem                      : memory-side bundle (master modport)
// -----------------------------------------------------------------------------
module cpu_request_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SEL_W   = DATA_W / 8,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 read_from_CPU,
   input  logic                 write_from_CPU,
   input  logic [SEL_W-1:0]     sel_from_CPU,
   input  logic [ADDR_W-1:0]    instruction_adr_from_CPU,
   input  logic [ADDR_W-1:0]    data_adr_from_CPU,
   input  logic [DATA_W-1:0]    data_from_CPU,
   output logic                 enable,
   output logic [DATA_W-1:0]    instruction,
   output logic [DATA_W-1:0]    data,
   output logic                 bus_error,
   cpu_request_arbiter_if.master mem
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit WDOG_EN = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] ADR_ZERO  = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DAT_ZERO  = {DATA_W{1'b0}};
   localparam logic [SEL_W-1:0]  SEL_ZERO  = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0]  SEL_ALL   = {SEL_W{1'b1}};

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      DATA  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] instruction_q, instruction_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              bus_error_q, bus_error_d;
   logic [CNT_W-1:0]  wdog_q, wdog_d;
   logic              req_active_s;

   assign instruction = instruction_q;
   assign data        = data_q;
   assign bus_error   = bus_error_q;

   // Next-state, memory request and enable decode.
   always_comb begin
      state_d           = state_q;
      instruction_d     = instruction_q;
      data_d            = data_q;
      bus_error_d       = bus_error_q;
      wdog_d            = CNT_ZERO;
      req_active_s      = 1'b0;
      enable            = 1'b0;
      mem.read_to_mem   = 1'b0;
      mem.write_to_mem  = 1'b0;
      mem.sel_to_mem    = SEL_ZERO;
      mem.adr_to_mem    = ADR_ZERO;
      mem.data_to_mem   = DAT_ZERO;

      // While reset is asserted nothing is presented, so no request can
      // complete against a memory that is itself being reset.
      if (nRst) begin
         case (state_q)
            FETCH: begin
               req_active_s    = 1'b1;
               mem.read_to_mem = 1'b1;
               mem.sel_to_mem  = SEL_ALL;
               mem.adr_to_mem  = instruction_adr_from_CPU;
               if (!mem.mem_busy) begin
                  instruction_d = mem.data_from_mem;
                  state_d       = EXEC;
               end else begin
                  state_d       = FETCH;
               end
            end
            EXEC: begin
               if (read_from_CPU || write_from_CPU) begin
                  state_d = DATA;
               end else begin
                  enable  = 1'b1;
                  state_d = FETCH;
               end
            end
            DATA: begin
               req_active_s     = 1'b1;
               mem.write_to_mem = write_from_CPU;
               mem.read_to_mem  = read_from_CPU & ~write_from_CPU;
               mem.sel_to_mem   = sel_from_CPU;
               mem.adr_to_mem   = data_adr_from_CPU;
               mem.data_to_mem  = data_from_CPU;
               if (!mem.mem_busy) begin
                  enable  = 1'b1;
                  state_d = FETCH;
                  if (read_from_CPU && !write_from_CPU) begin
                     data_d = mem.data_from_mem;
                  end else begin
                     data_d = data_q;
                  end
               end else begin
                  state_d = DATA;
               end
            end
            ERROR: begin
               state_d = ERROR;
            end
            default: begin
               state_d = FETCH;
            end
         endcase

         // Watchdog: counts busy cycles of the current request; any
         // completion or state change leaves it cleared.
         if (WDOG_EN && req_active_s && mem.mem_busy) begin
            wdog_d = wdog_q + CNT_ONE;
            if (wdog_d == CNT_LIMIT) begin
               state_d     = ERROR;
               bus_error_d = 1'b1;
            end else begin
               bus_error_d = bus_error_q;
            end
         end else begin
            wdog_d = CNT_ZERO;
         end
      end else begin
         state_d = FETCH;
      end
   end

   // State, output and watchdog registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q       <= FETCH;
         instruction_q <= DAT_ZERO;
         data_q        <= DAT_ZERO;
         bus_error_q   <= 1'b0;
         wdog_q        <= CNT_ZERO;
      end else begin
         state_q       <= state_d;
         instruction_q <= instruction_d;
         data_q        <= data_d;
         bus_error_q   <= bus_error_d;
         wdog_q        <= wdog_d;
      end
   end

endmodule
